ws2811_serial_receiver: RTL and testbench
=========================================

# ws2811_serial_receiver

Decodes a WS2811 single-wire NRZ pixel stream the way a physical WS2811 pixel does. It captures the first 24 bits after a line reset as the pixel's own colour word and forwards every later bit unchanged on `serial_out` to the next pixel. The colour word is committed when the reset (latch) low period is detected. It is the receive-side counterpart of the team's array controller and serves as an on-chip pixel model for loopback test and chaining.

## Interface
- `T_SAMPLE`, 22: clocks after the detected rising edge at which the bit value is sampled (0.44 µs at 50 MHz).
- `T_RESET`, 2500: consecutive low clocks that constitute a latch/reset (50 µs at 50 MHz); ≥ 2·T_SAMPLE.
- `clock` in 1: single clock domain, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `serial_in` in 1: asynchronous WS2811 data line, idle low.
- `serial_out` out 1: forwarded stream (bits 25 onward), low otherwise.
- `rgb_data` out 24: last committed colour word; first received bit is `rgb_data[23]`, no reordering.
- `rgb_valid` out 1: one-cycle pulse when `rgb_data` updates.
- `frame_error` out 1: one-cycle pulse when a latch discards a malformed frame.
- `busy` out 1: high from the first rising edge of a frame until its latch.
- `db_state` out 2: FSM state (SYNC=0, IDLE=1, HIGH=2, LOW=3).

## Operation
- Input path: 2-FF synchronizer, giving `sync_q`, plus a previous-value register; rising edge = `sync_q` & !prev.
- Low counter: increments on each clock with `sync_q`=0, clears on `sync_q`=1, and saturates at T_RESET. The latch event is the single clock where it reaches T_RESET.
- SYNC (after reset): ignore all edges until the first latch event, then go to IDLE. No `rgb_valid` or `frame_error` is raised.
- IDLE: on a rising edge, go to HIGH, clear the bit timer, and set `busy`.
- HIGH: the bit timer counts. When the timer reaches T_SAMPLE, sample `sync_q` as the bit value and go to LOW. If the line falls first, keep waiting for the sample point; the bit will read 0.
- LOW: on a rising edge, go to HIGH (next bit). On a latch event, perform the commit and go to IDLE.
- HIGH, short-bit case: a rising edge before the sample point (line fell and rose again) restarts the bit and sets the sticky `bad` flag.
- Capture: while the bit count is < 24, shift the sampled bit into a 24-bit shift register MSB-first. The bit count is 5 bits and saturates at 24.
- Forwarding: `fwd` sets on the first rising edge after the 24th bit was sampled. While `fwd`=1, `serial_out` is registered `sync_q`. Bits forwarded are not counted.
- Commit on latch, count = 24 and !`bad`: `rgb_data` ← shift register; pulse `rgb_valid`.
- Commit on latch, 0 < count < 24 or `bad`: pulse `frame_error`; `rgb_data` is unchanged.
- Commit on latch, count = 0: no pulse.
- Every commit clears the count, `bad`, `fwd` and `busy`.
- A line stuck high never latches; the FSM stays in HIGH or LOW, waiting.

## Timing
- Reset values: `serial_out`=0, `rgb_data`=24'h000000, `rgb_valid`=0, `frame_error`=0, `busy`=0, `db_state`=0 (SYNC). Reset takes effect immediately, mid-frame included; the partial frame is lost.
- Synchronizer latency is 2 clocks. When forwarding, `serial_out` equals `serial_in` delayed exactly 3 clocks, edge-for-edge, with pulse widths preserved.
- Bit decode: a high pulse lasting more than T_SAMPLE clocks decodes as 1; ≤ T_SAMPLE clocks decodes as 0.
- `rgb_valid`/`frame_error` go high T_RESET+1 clocks after the edge that first samples `serial_in` low, and last exactly 1 cycle. `rgb_data` is stable from that same edge.
- A rising edge arriving in the same cycle as the latch event is ignored. The next frame starts on the following rising edge.
- Throughput: one bit per rising edge. There is no minimum low time beyond one clock.

## Test plan
- Reset then sync: assert `reset`=0 mid-activity, release, hold the line low for 2500 clocks → `db_state` goes 0→1; no pulses; all outputs at reset values.
- Single pixel: T0H=12/T1H=30, 62-clock bit period, word 24'hA5C33C, then 2500 low → `rgb_valid` one cycle, `rgb_data`=A5C33C, `serial_out` stays 0.
- Chain forward: send 48 bits 24'h123456 then 24'hFFFFFF, then latch → `rgb_data`=123456. `serial_out` reproduces bits 25–48 delayed by 3 clocks, with 30-clock highs.
- Short frame: 10 bits then latch → `frame_error` pulse; `rgb_data` keeps its previous value; the next valid frame commits normally.
- Boundary decode: highs of exactly 22 and 23 clocks → decode as 0 and 1 respectively.
- Boundary latch: low gaps of 2499 clocks → no latch. A gap of 2500 clocks → latch.
- Reset mid-forward: drop `reset` during bit 30 → `serial_out`=0 at once; FSM returns to SYNC; `rgb_data`=0.

Source files
------------

// File: rtl/ws2811_serial_receiver.sv
// rtl/ws2811_serial_receiver.sv - WS2811 pixel receiver: keeps the first 24 bits after a latch, forwards the rest
module ws2811_serial_receiver #(
    parameter int T_SAMPLE = 22,
    parameter int T_RESET  = 2500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial_in,
    output logic        serial_out,
    output logic [23:0] rgb_data,
    output logic        rgb_valid,
    output logic        frame_error,
    output logic        busy,
    output logic [1:0]  db_state
);
    localparam int LOW_W = $clog2(T_RESET + 1);
    localparam int TMR_W = $clog2(T_SAMPLE + 1);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    logic             meta_q, sync_q, prev_q;
    logic [LOW_W-1:0] low_cnt_q, low_cnt_d;
    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
    logic [23:0]      shift_q, shift_d;
    logic [23:0]      rgb_q, rgb_d;
    logic [4:0]       count_q, count_d;
    logic             bad_q, bad_d;
    logic             fwd_q, fwd_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             out_q, out_d;
    logic             rise, latch, commit;

    assign rise      = sync_q & ~prev_q;
    // Fires only on the clock where the low counter steps onto T_RESET.
    assign latch     = ~sync_q & (low_cnt_q == LOW_W'(T_RESET - 1));
    assign timer_inc = timer_q + TMR_W'(1);

    always_comb begin
        low_cnt_d = low_cnt_q;
        if (sync_q) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != LOW_W'(T_RESET)) begin
            low_cnt_d = low_cnt_q + LOW_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        shift_d = shift_q;
        rgb_d   = rgb_q;
        count_d = count_q;
        bad_d   = bad_q;
        fwd_d   = fwd_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        commit  = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (latch) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_HIGH;
                    timer_d = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_HIGH: begin
                if (rise) begin
                    timer_d = '0;
                    bad_d   = 1'b1;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TMR_W'(T_SAMPLE)) begin
                        state_d = ST_LOW;
                        if (count_q < 5'd24) begin
                            shift_d = {shift_q[22:0], sync_q};
                            count_d = count_q + 5'd1;
                        end
                    end
                end
            end
            ST_LOW: begin
                if (latch) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end else if (rise) begin
                    state_d = ST_HIGH;
                    timer_d = '0;
                    if (count_q == 5'd24) fwd_d = 1'b1;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        if (commit) begin
            if (count_q == 5'd24 && !bad_q) begin
                rgb_d   = shift_q;
                valid_d = 1'b1;
            end else if (count_q != 5'd0) begin
                err_d = 1'b1;
            end
            count_d = '0;
            bad_d   = 1'b0;
            fwd_d   = 1'b0;
            busy_d  = 1'b0;
        end

        // Using fwd_d lets the rising edge that opens forwarding pass through unclipped.
        out_d = fwd_d & sync_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            prev_q    <= 1'b0;
            low_cnt_q <= '0;
            state_q   <= ST_SYNC;
            timer_q   <= '0;
            shift_q   <= '0;
            rgb_q     <= '0;
            count_q   <= '0;
            bad_q     <= 1'b0;
            fwd_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            meta_q    <= serial_in;
            sync_q    <= meta_q;
            prev_q    <= sync_q;
            low_cnt_q <= low_cnt_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            rgb_q     <= rgb_d;
            count_q   <= count_d;
            bad_q     <= bad_d;
            fwd_q     <= fwd_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            out_q     <= out_d;
        end
    end

    assign serial_out  = out_q;
    assign rgb_data    = rgb_q;
    assign rgb_valid   = valid_q;
    assign frame_error = err_q;
    assign busy        = busy_q;
    assign db_state    = state_q;
endmodule

// File: tb/tb_ws2811_serial_receiver.sv
// tb/tb_ws2811_serial_receiver.sv - bench for ws2811_serial_receiver against a frame-level pixel model
module tb_ws2811_serial_receiver;
    localparam int T_SAMPLE = 22;
    localparam int T_RESET  = 2500;

    logic        clock = 1'b0;
    logic        reset;
    logic        serial_in;
    logic        serial_out;
    logic [23:0] rgb_data;
    logic        rgb_valid;
    logic        frame_error;
    logic        busy;
    logic [1:0]  db_state;

    ws2811_serial_receiver #(.T_SAMPLE(T_SAMPLE), .T_RESET(T_RESET)) dut (
        .clock      (clock),
        .reset      (reset),
        .serial_in  (serial_in),
        .serial_out (serial_out),
        .rgb_data   (rgb_data),
        .rgb_valid  (rgb_valid),
        .frame_error(frame_error),
        .busy       (busy),
        .db_state   (db_state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        so;
        logic        busy;
        logic        valid;
        logic        err;
        logic [23:0] rgb;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Pixel model: line-level latch detection plus a bit list for the current frame.
    logic        m_synced, m_active;
    int          m_count, m_low_run;
    logic [23:0] m_word, m_rgb;

    int   valid_cnt = 0, err_cnt = 0, so_high = 0, so_edges = 0;
    logic so_prev = 1'b0;

    always @(negedge clock) begin
        if (rgb_valid === 1'b1) valid_cnt <= valid_cnt + 1;
        if (frame_error === 1'b1) err_cnt <= err_cnt + 1;
        if (serial_out === 1'b1) so_high <= so_high + 1;
        if (serial_out === 1'b1 && so_prev === 1'b0) so_edges <= so_edges + 1;
        so_prev <= serial_out;
    end

    task automatic check1(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Each input cycle is visible on the outputs three clocks later.
    task automatic step(input logic v, input logic tag);
        obs_t e, o;
        logic pv, pe;
        @(negedge clock);
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            o = {serial_out, busy, rgb_valid, frame_error, rgb_data};
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL cycle observed=%h expected=%h", o, e);
            end
        end
        serial_in = v;
        pv = 1'b0;
        pe = 1'b0;
        if (v) begin
            m_low_run = 0;
        end else begin
            m_low_run++;
            if (m_low_run == T_RESET) begin
                if (!m_synced) begin
                    m_synced = 1'b1;
                end else if (m_count == 24) begin
                    m_rgb = m_word;
                    pv = 1'b1;
                end else if (m_count > 0) begin
                    pe = 1'b1;
                end
                m_count  = 0;
                m_active = 1'b0;
            end
        end
        e = {v & tag, m_active, pv, pe, m_rgb};
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input int h, input int l);
        logic tag;
        tag = 1'b0;
        if (m_synced) begin
            m_active = 1'b1;
            if (m_count == 24) begin
                tag = 1'b1;
            end else begin
                m_word = {m_word[22:0], (h > T_SAMPLE)};
                m_count++;
            end
        end
        repeat (h) step(1'b1, tag);
        repeat (l) step(1'b0, tag);
    endtask

    task automatic send_word(input logic [23:0] w, input int nbits, input int h0, input int h1, input int period);
        int h;
        for (int i = 0; i < nbits; i++) begin
            h = w[23-i] ? h1 : h0;
            send_bit(h, period - h);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic release_reset();
        obs_t z;
        z = '0;
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        exp_q.push_back(z);
        exp_q.push_back(z);
        m_synced  = 1'b0;
        m_active  = 1'b0;
        m_count   = 0;
        m_word    = '0;
        m_rgb     = '0;
        m_low_run = 3;
        exp_q.push_back(z);
    endtask

    task automatic drop_reset(input string tag);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check1({tag, "_serial_out"}, {23'd0, serial_out}, 24'd0);
        check1({tag, "_state"}, {22'd0, db_state}, 24'd0);
        check1({tag, "_rgb"}, rgb_data, 24'd0);
        check1({tag, "_flags"}, {21'd0, busy, rgb_valid, frame_error}, 24'd0);
        serial_in = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int v0, e0, h0, n0, nb, h, l;
        logic [23:0] w;
        reset = 1'b0;
        serial_in = 1'b0;
        repeat (3) @(negedge clock);
        release_reset();
        for (int i = 0; i < 4; i++) send_bit(30, 32);
        repeat (7) step(1'b1, 1'b0);
        drop_reset("reset_mid");
        release_reset();
        gap(T_RESET + 10);
        check1("sync_state", {22'd0, db_state}, 24'd1);

        v0 = valid_cnt; h0 = so_high;
        send_word(24'hA5C33C, 24, 12, 30, 62);
        gap(T_RESET + 10);
        check1("pixel_rgb", rgb_data, 24'hA5C33C);
        check1("pixel_valid_count", valid_cnt - v0, 24'd1);
        check1("pixel_serial_out", so_high - h0, 24'd0);

        v0 = valid_cnt; h0 = so_high; n0 = so_edges;
        send_word(24'h123456, 24, 12, 30, 62);
        send_word(24'hFFFFFF, 24, 12, 30, 62);
        gap(T_RESET + 10);
        check1("chain_rgb", rgb_data, 24'h123456);
        check1("chain_fwd_high", so_high - h0, 24'd720);
        check1("chain_fwd_edges", so_edges - n0, 24'd24);

        v0 = valid_cnt; e0 = err_cnt;
        send_word(24'hB4C000, 10, 12, 30, 62);
        gap(T_RESET + 10);
        check1("short_error", err_cnt - e0, 24'd1);
        check1("short_no_valid", valid_cnt - v0, 24'd0);
        check1("short_rgb_kept", rgb_data, 24'h123456);
        send_word(24'h0F1E2D, 24, 12, 30, 62);
        gap(T_RESET + 10);
        check1("after_short_rgb", rgb_data, 24'h0F1E2D);

        send_word(24'hC3A55A, 24, 22, 23, 62);
        gap(T_RESET + 10);
        check1("decode_22_23", rgb_data, 24'hC3A55A);

        v0 = valid_cnt; e0 = err_cnt;
        w = 24'h5AF00F;
        for (int i = 0; i < 24; i++) begin
            h = w[23-i] ? 30 : 12;
            l = (i == 11) ? T_RESET - 1 : 62 - h;
            send_bit(h, l);
            if (i == 11) check1("gap_2499_state", {22'd0, db_state}, 24'd3);
        end
        check1("gap_2499_no_pulse", (valid_cnt - v0) + (err_cnt - e0), 24'd0);
        gap(T_RESET);
        gap(10);
        check1("gap_2500_rgb", rgb_data, 24'h5AF00F);
        check1("gap_2500_state", {22'd0, db_state}, 24'd1);

        for (int f = 0; f < 6; f++) begin
            nb = $urandom_range(0, 36);
            for (int i = 0; i < nb; i++) begin
                h = $urandom_range(5, 40);
                l = $urandom_range((h > T_SAMPLE) ? 1 : T_SAMPLE + 1 - h, 30);
                if ($urandom_range(0, 15) == 0) l = $urandom_range(T_RESET - 40, T_RESET - 1);
                send_bit(h, l);
            end
            gap(T_RESET + 10);
            check1("random_rgb", rgb_data, m_rgb);
        end

        send_word(24'h0A0B0C, 24, 12, 30, 62);
        send_word(24'hF80000, 5, 12, 30, 62);
        m_active = 1'b1;
        repeat (10) step(1'b1, 1'b1);
        check1("fwd_before_reset", {23'd0, serial_out}, 24'd1);
        drop_reset("reset_fwd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
